// File: rtl/sram_ctrl.sv
// sram_ctrl: sequences CE/WE/OE strobes for one word access to an asynchronous SRAM and owns its tristate data bus.
// Optional build macro SRAM_CTRL_AUTOINC_EN adds req_inc, which reuses the last accessed address plus one.
`timescale 1ns/1ps
module sram_ctrl #(
   parameter int ADDRESSSIZE = 19,
   parameter int WORDSIZE    = 8,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req,
   input  logic                   req_wr,
   input  logic [ADDRESSSIZE-1:0] req_addr,
   input  logic [WORDSIZE-1:0]    req_wdata,
`ifdef SRAM_CTRL_AUTOINC_EN
   input  logic                   req_inc,
`endif
   output logic                   ready,
   output logic                   rd_valid,
   output logic [WORDSIZE-1:0]    rd_data,
   output logic [ADDRESSSIZE-1:0] sram_addr,
   inout  wire  [WORDSIZE-1:0]    sram_data,
   output logic                   sram_cen,
   output logic                   sram_wen,
   output logic                   sram_oen
);

   localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

   state_t                 state, state_nxt;
   logic [CNT_W-1:0]       cnt, cnt_nxt;
   logic                   wr_op, wr_op_nxt;
   logic [ADDRESSSIZE-1:0] addr_q, addr_nxt;
   logic [WORDSIZE-1:0]    wdata_q, wdata_nxt;
   logic [WORDSIZE-1:0]    rd_data_q, rd_data_nxt;
   logic [ADDRESSSIZE-1:0] acc_addr;

   logic ready_q, rd_valid_q, cen_q, wen_q, oen_q, drive_q;
   logic ready_nxt, rd_valid_nxt, cen_nxt, wen_nxt, oen_nxt, drive_nxt;

   // The address register doubles as the streaming pointer: it always holds the last accessed word.
`ifdef SRAM_CTRL_AUTOINC_EN
   assign acc_addr = req_inc ? (addr_q + ADDRESSSIZE'(1)) : req_addr;
`else
   assign acc_addr = req_addr;
`endif

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      wr_op_nxt   = wr_op;
      addr_nxt    = addr_q;
      wdata_nxt   = wdata_q;
      rd_data_nxt = rd_data_q;

      unique case (state)
         IDLE: begin
            if (req) begin
               state_nxt = SETUP;
               wr_op_nxt = req_wr;
               addr_nxt  = acc_addr;
               wdata_nxt = req_wdata;
            end
         end
         SETUP: begin
            state_nxt = ACCESS;
            cnt_nxt   = CNT_W'(WAIT_CYCLES);
         end
         ACCESS: begin
            if (cnt == '0) begin
               state_nxt = HOLD;
               if (!wr_op) begin
                  rd_data_nxt = sram_data;
               end
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         HOLD: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Pin values are decoded from the upcoming state so every strobe is a flop output aligned with it.
      ready_nxt    = (state_nxt == IDLE);
      cen_nxt      = (state_nxt == IDLE);
      wen_nxt      = !((state_nxt == ACCESS) && wr_op_nxt);
      oen_nxt      = !(((state_nxt == SETUP) || (state_nxt == ACCESS)) && !wr_op_nxt);
      drive_nxt    = (state_nxt != IDLE) && wr_op_nxt;
      rd_valid_nxt = (state_nxt == HOLD) && !wr_op_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         wr_op     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rd_data_q <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         wr_op     <= wr_op_nxt;
         addr_q    <= addr_nxt;
         wdata_q   <= wdata_nxt;
         rd_data_q <= rd_data_nxt;
      end
   end

   // Reset releases the strobes and the bus immediately, even mid-access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q    <= 1'b1;
         rd_valid_q <= 1'b0;
         cen_q      <= 1'b1;
         wen_q      <= 1'b1;
         oen_q      <= 1'b1;
         drive_q    <= 1'b0;
      end else begin
         ready_q    <= ready_nxt;
         rd_valid_q <= rd_valid_nxt;
         cen_q      <= cen_nxt;
         wen_q      <= wen_nxt;
         oen_q      <= oen_nxt;
         drive_q    <= drive_nxt;
      end
   end

   assign ready     = ready_q;
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
   assign sram_addr = addr_q;
   assign sram_cen  = cen_q;
   assign sram_wen  = wen_q;
   assign sram_oen  = oen_q;
   assign sram_data = drive_q ? wdata_q : {WORDSIZE{1'bz}};

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: scoreboard bench for sram_ctrl (WAIT_CYCLES=1 and 0) with a behavioural SRAM on the bus.
// Defining SRAM_CTRL_AUTOINC_EN adds the address auto-increment scenario.
`timescale 1ns/1ps
module tb_sram_ctrl;
   localparam int AW = 19;
   localparam int DW = 8;
   localparam int W1 = 1;
   localparam logic [DW-1:0] PROBE = 8'hA5;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic          req, req0, req_wr;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
`ifdef SRAM_CTRL_AUTOINC_EN
   logic          req_inc;
`endif
   logic          ready, rd_valid, sram_cen, sram_wen, sram_oen;
   logic [DW-1:0] rd_data;
   logic [AW-1:0] sram_addr;
   wire  [DW-1:0] sram_data;
   logic          ready0, rd_valid0, sram_cen0, sram_wen0, sram_oen0;
   logic [DW-1:0] rd_data0;
   logic [AW-1:0] sram_addr0;
   wire  [DW-1:0] sram_data0;

   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] ref_mem [logic [AW-1:0]];
   logic [DW-1:0] rd_q[$];
   logic [DW-1:0] rd0_q[$];
   logic [DW-1:0] exp_rd, exp_rd0;
   logic          probe_en;
   logic          tb_en;
   logic [DW-1:0] tb_val;
   int            n_checks = 0;
   int            n_fail = 0;
   int            n_rdv0 = 0;

   sram_ctrl #(.ADDRESSSIZE(AW), .WORDSIZE(DW), .WAIT_CYCLES(W1)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef SRAM_CTRL_AUTOINC_EN
      .req_inc(req_inc),
`endif
      .ready(ready), .rd_valid(rd_valid), .rd_data(rd_data), .sram_addr(sram_addr), .sram_data(sram_data),
      .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_oen(sram_oen)
   );

   sram_ctrl #(.ADDRESSSIZE(AW), .WORDSIZE(DW), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .req(req0), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef SRAM_CTRL_AUTOINC_EN
      .req_inc(1'b0),
`endif
      .ready(ready0), .rd_valid(rd_valid0), .rd_data(rd_data0), .sram_addr(sram_addr0), .sram_data(sram_data0),
      .sram_cen(sram_cen0), .sram_wen(sram_wen0), .sram_oen(sram_oen0)
   );

   // SRAM model: drives on CE+OE, latches on the rising WE edge; PROBE marks a bus nobody else should drive.
   always_comb begin
      tb_en  = 1'b0;
      tb_val = '0;
      if (!sram_cen && !sram_oen) begin
         tb_en  = 1'b1;
         tb_val = mem[sram_addr];
      end else if (probe_en) begin
         tb_en  = 1'b1;
         tb_val = PROBE;
      end
   end
   assign sram_data  = tb_en ? tb_val : {DW{1'bz}};
   assign sram_data0 = (!sram_cen0 && !sram_oen0) ? mem[sram_addr0] : {DW{1'bz}};

   always @(posedge sram_wen) begin
      if (!sram_cen) mem[sram_addr] <= sram_data;
   end

   // Scoreboard pops: every rd_valid pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && rd_valid) begin
         n_checks++;
         if (rd_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL rd_pop: rd_valid with nothing expected, rd_data=%h", rd_data);
         end else begin
            exp_rd = rd_q.pop_front();
            if (rd_data !== exp_rd) begin
               n_fail++;
               $display("[TB] FAIL rd_data: got %h want %h", rd_data, exp_rd);
            end
         end
      end
      if (rst_n && rd_valid0) begin
         n_checks++;
         n_rdv0++;
         if (rd0_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL rd0_pop: rd_valid with nothing expected, rd_data=%h", rd_data0);
         end else begin
            exp_rd0 = rd0_q.pop_front();
            if (rd_data0 !== exp_rd0) begin
               n_fail++;
               $display("[TB] FAIL rd0_data: got %h want %h", rd_data0, exp_rd0);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         n_checks++;
         if ((!sram_wen && !sram_oen) || (!sram_wen0 && !sram_oen0)) begin
            n_fail++;
            $display("[TB] FAIL wen_oen_overlap: wen=%b oen=%b wen0=%b oen0=%b, want never both 0",
                     sram_wen, sram_oen, sram_wen0, sram_oen0);
         end
      end
   end

   // Expected {ready, cen, wen, oen, rd_valid} in cycle c after acceptance, for w wait cycles.
   function automatic logic [4:0] exp_cycle(input logic wr, input int c, input int w);
      if (c == 1)          return wr ? 5'b00110 : 5'b00100;
      else if (c <= w + 2) return wr ? 5'b00010 : 5'b00100;
      else if (c == w + 3) return wr ? 5'b00110 : 5'b00111;
      else                 return 5'b11110;
   endfunction

   task automatic dut_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      int t;
      @(negedge clk); #1;
      req = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d;
      @(negedge clk); #1;
      req = 1'b0;
      t = 0;
      while (!ready && t < 20) begin
         @(negedge clk); #1;
         t++;
      end
      n_checks++;
      if (ready !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL write_done: ready=%b after %0d cycles, want 1", ready, t);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      probe_en = 1'b1;
      @(negedge clk); #1;
      n_checks++;
      if ({ready, sram_cen, sram_wen, sram_oen, rd_valid} !== 5'b11110) begin
         n_fail++;
         $display("[TB] FAIL reset_strobes: got %b want 11110", {ready, sram_cen, sram_wen, sram_oen, rd_valid});
      end
      n_checks++;
      if ({ready0, sram_cen0, sram_wen0, sram_oen0, rd_valid0} !== 5'b11110) begin
         n_fail++;
         $display("[TB] FAIL reset_strobes0: got %b want 11110", {ready0, sram_cen0, sram_wen0, sram_oen0, rd_valid0});
      end
      n_checks++;
      if (rd_data !== 8'h00 || sram_addr !== 19'h0) begin
         n_fail++;
         $display("[TB] FAIL reset_regs: rd_data=%h sram_addr=%h want 00 00000", rd_data, sram_addr);
      end
      n_checks++;
      if (sram_data !== PROBE) begin
         n_fail++;
         $display("[TB] FAIL reset_bus: bus=%h want %h (released)", sram_data, PROBE);
      end
      @(negedge clk);
      rst_n = 1'b1;
      probe_en = 1'b0;
   endtask

   task automatic test_write;
      logic [4:0] e;
      @(negedge clk); #1;
      req = 1'b1; req_wr = 1'b1; req_addr = 19'h00123; req_wdata = 8'h5A;
      ref_mem[19'h00123] = 8'h5A;
      for (int c = 1; c <= W1 + 4; c++) begin
         @(negedge clk);
         probe_en = (c == W1 + 4);
         #1;
         e = exp_cycle(1'b1, c, W1);
         n_checks++;
         if ({ready, sram_cen, sram_wen, sram_oen, rd_valid} !== e) begin
            n_fail++;
            $display("[TB] FAIL write_strobes c%0d: got %b want %b", c, {ready, sram_cen, sram_wen, sram_oen, rd_valid}, e);
         end
         n_checks++;
         if (c < W1 + 4) begin
            if (sram_data !== 8'h5A || sram_addr !== 19'h00123) begin
               n_fail++;
               $display("[TB] FAIL write_bus c%0d: bus=%h addr=%h want 5a 00123", c, sram_data, sram_addr);
            end
         end else if (sram_data !== PROBE) begin
            n_fail++;
            $display("[TB] FAIL write_release: bus=%h want %h", sram_data, PROBE);
         end
         req = 1'b0; req_addr = 19'h7FFFF; req_wdata = 8'hFF;
      end
      probe_en = 1'b0;
      n_checks++;
      if (mem[19'h00123] !== 8'h5A) begin
         n_fail++;
         $display("[TB] FAIL write_mem: mem[00123]=%h want 5a", mem[19'h00123]);
      end
   endtask

   task automatic test_read;
      logic [4:0] e;
      @(negedge clk); #1;
      req = 1'b1; req_wr = 1'b0; req_addr = 19'h00123; req_wdata = 8'h00;
      rd_q.push_back(ref_mem[19'h00123]);
      for (int c = 1; c <= W1 + 4; c++) begin
         @(negedge clk);
         probe_en = (c >= W1 + 3);
         #1;
         e = exp_cycle(1'b0, c, W1);
         n_checks++;
         if ({ready, sram_cen, sram_wen, sram_oen, rd_valid} !== e) begin
            n_fail++;
            $display("[TB] FAIL read_strobes c%0d: got %b want %b", c, {ready, sram_cen, sram_wen, sram_oen, rd_valid}, e);
         end
         n_checks++;
         if (sram_data !== ((c <= W1 + 2) ? 8'h5A : PROBE)) begin
            n_fail++;
            $display("[TB] FAIL read_bus c%0d: bus=%h want %h", c, sram_data, (c <= W1 + 2) ? 8'h5A : PROBE);
         end
         req = 1'b0; req_addr = 19'h00777;
      end
      repeat (3) @(negedge clk);
      #1;
      probe_en = 1'b0;
      n_checks++;
      if (rd_data !== 8'h5A) begin
         n_fail++;
         $display("[TB] FAIL read_hold: rd_data=%h want 5a", rd_data);
      end
   endtask

   task automatic test_back_to_back;
      int acc[$];
      int ops;
      logic [AW-1:0] a;
      ops = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk); #1;
         if (ready) begin
            if (ops < 6) begin
               a = 19'h00200 + AW'(ops / 2);
               req = 1'b1;
               req_addr = a;
               if (ops % 2 == 0) begin
                  req_wr = 1'b1;
                  req_wdata = 8'h10 + 8'(ops);
                  ref_mem[a] = req_wdata;
               end else begin
                  req_wr = 1'b0;
                  rd_q.push_back(ref_mem[a]);
               end
               acc.push_back(c);
               ops++;
            end else begin
               req = 1'b0;
            end
         end else begin
            req_wr = ~req_wr; req_addr = 19'h05555; req_wdata = 8'hEE;
         end
      end
      n_checks++;
      if (ops != 6) begin
         n_fail++;
         $display("[TB] FAIL b2b_ops: accepted %0d want 6", ops);
      end
      for (int i = 1; i < acc.size(); i++) begin
         n_checks++;
         if (acc[i] - acc[i-1] != W1 + 4) begin
            n_fail++;
            $display("[TB] FAIL b2b_period op%0d: got %0d want %0d", i, acc[i] - acc[i-1], W1 + 4);
         end
      end
      for (int k = 0; k < 3; k++) begin
         a = 19'h00200 + AW'(k);
         n_checks++;
         if (mem[a] !== 8'h10 + 8'(2 * k)) begin
            n_fail++;
            $display("[TB] FAIL b2b_mem %h: got %h want %h", a, mem[a], 8'h10 + 8'(2 * k));
         end
      end
   endtask

   task automatic test_reset_mid_write;
      @(negedge clk); #1;
      req = 1'b1; req_wr = 1'b1; req_addr = 19'h00300; req_wdata = 8'h77;
      @(negedge clk); #1;
      req = 1'b0;
      @(negedge clk); #1;
      n_checks++;
      if (sram_wen !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL rst_pre_access: wen=%b want 0", sram_wen);
      end
      rst_n = 1'b0;
      probe_en = 1'b1;
      #1;
      n_checks++;
      if ({sram_cen, sram_wen, sram_oen} !== 3'b111 || sram_data !== PROBE) begin
         n_fail++;
         $display("[TB] FAIL rst_async: cen/wen/oen=%b bus=%h want 111 %h", {sram_cen, sram_wen, sram_oen}, sram_data, PROBE);
      end
      @(negedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk); #1;
      n_checks++;
      if (ready !== 1'b1 || rd_data !== 8'h00 || rd_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL rst_after: ready=%b rd_data=%h rd_valid=%b want 1 00 0", ready, rd_data, rd_valid);
      end
      probe_en = 1'b0;
   endtask

   task automatic test_w0_back_to_back;
      int acc[$];
      int ops;
      dut_write(19'h7FFFF, 8'h3C);
      dut_write(19'h00000, 8'hC3);
      n_checks++;
      if (mem[19'h7FFFF] !== 8'h3C || mem[19'h00000] !== 8'hC3) begin
         n_fail++;
         $display("[TB] FAIL w0_preload: mem[7ffff]=%h mem[0]=%h want 3c c3", mem[19'h7FFFF], mem[19'h00000]);
      end
      n_rdv0 = 0;
      ops = 0;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk); #1;
         if (ready0) begin
            if (ops < 2) begin
               req0 = 1'b1; req_wr = 1'b0;
               req_addr = (ops == 0) ? 19'h7FFFF : 19'h00000;
               rd0_q.push_back((ops == 0) ? 8'h3C : 8'hC3);
               acc.push_back(c);
               ops++;
            end else begin
               req0 = 1'b0;
            end
         end
      end
      n_checks++;
      if (ops != 2 || acc.size() != 2) begin
         n_fail++;
         $display("[TB] FAIL w0_ops: accepted %0d want 2", ops);
      end else begin
         n_checks++;
         if (acc[1] - acc[0] != 4) begin
            n_fail++;
            $display("[TB] FAIL w0_period: got %0d want 4", acc[1] - acc[0]);
         end
      end
      n_checks++;
      if (n_rdv0 != 2) begin
         n_fail++;
         $display("[TB] FAIL w0_pulses: rd_valid pulses %0d want 2", n_rdv0);
      end
   endtask

`ifdef SRAM_CTRL_AUTOINC_EN
   task automatic test_autoinc;
      req_inc = 1'b0;
      dut_write(19'h7FFFF, 8'hAA);
      req_inc = 1'b1;
      dut_write(19'h12345, 8'hBB);
      req_inc = 1'b0;
      n_checks++;
      if (mem[19'h00000] !== 8'hBB || mem[19'h7FFFF] !== 8'hAA || mem[19'h12345] === 8'hBB) begin
         n_fail++;
         $display("[TB] FAIL autoinc_wrap: mem[0]=%h mem[7ffff]=%h mem[12345]=%h want bb aa not-bb",
                  mem[19'h00000], mem[19'h7FFFF], mem[19'h12345]);
      end
   endtask
`endif

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      req = 1'b0; req0 = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
      probe_en = 1'b0;
`ifdef SRAM_CTRL_AUTOINC_EN
      req_inc = 1'b0;
`endif
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_reset_mid_write();
      test_w0_back_to_back();
`ifdef SRAM_CTRL_AUTOINC_EN
      test_autoinc();
`endif
      repeat (6) @(negedge clk);
      #1;
      n_checks++;
      if (rd_q.size() != 0 || rd0_q.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL scoreboard_drain: %0d and %0d reads never completed", rd_q.size(), rd0_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
